// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types, constants and priority encoder for the interrupt controller
package irq_pkg;

    localparam int N_IRQ_DEFAULT = 3;
    localparam int IDW           = $clog2(N_IRQ_DEFAULT);
    localparam int PW            = 5;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } irq_state_t;

    typedef struct packed {
        logic          none;
        logic [PW-1:0] idx;
    } prio_t;

    // Highest set bit of v; none=1 when v is all zero.
    function automatic prio_t prio_enc(input logic [31:0] v);
        prio_t res;
        res.none = 1'b1;
        res.idx  = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                res.none = 1'b0;
                res.idx  = PW'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// rtl/irq_edge_sync.sv - two-flop synchroniser plus rising-edge detector for one line
module irq_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    output logic irq_edge
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= irq_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign irq_edge = r_s2 & ~r_s3;

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - prioritised, nesting interrupt sequencer for the datapath
module irq_controller
    import irq_pkg::*;
#(
    parameter int          N_IRQ      = N_IRQ_DEFAULT,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'd4,
    localparam int         W_ID       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             irq_en,
    input  logic             irq_ack,
    input  logic             uret,
    output logic             irq_req,
    output logic [W_ID-1:0]  irq_id,
    output logic [31:0]      irq_vector,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] in_service
);

    logic [N_IRQ-1:0] w_edge;
    logic [N_IRQ-1:0] w_above;
    logic [N_IRQ-1:0] w_uret_clr;
    logic [N_IRQ-1:0] w_ack_set;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_in_service;
    prio_t            w_cur;
    prio_t            w_cand;

    irq_state_t       r_state;
    irq_state_t       w_state_next;
    logic             r_irq_req;
    logic             w_req_next;
    logic [W_ID-1:0]  r_irq_id;
    logic [W_ID-1:0]  w_id_next;
    logic [31:0]      r_irq_vector;
    logic [31:0]      w_vec_next;

    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_sync
        irq_edge_sync u_sync (
            .clk      (clk),
            .rst      (rst),
            .irq_in   (irq_in[gi]),
            .irq_edge (w_edge[gi])
        );
    end

    // Only lines strictly above the current in-service level may preempt.
    always_comb begin
        w_cur      = prio_enc(32'(r_in_service));
        w_above    = '0;
        w_uret_clr = '0;
        w_ack_set  = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            w_above[i]    = w_cur.none || (PW'(i) > w_cur.idx);
            w_uret_clr[i] = uret && !w_cur.none && (w_cur.idx == PW'(i));
            w_ack_set[i]  = (r_state == REQ) && irq_ack && (r_irq_id == W_ID'(i));
        end
        w_cand = prio_enc(32'(r_pending & w_above));
    end

    always_comb begin
        w_state_next = r_state;
        w_req_next   = r_irq_req;
        w_id_next    = r_irq_id;
        w_vec_next   = r_irq_vector;
        case (r_state)
            IDLE: begin
                w_req_next = 1'b0;
                if (irq_en && !w_cand.none) begin
                    w_state_next = REQ;
                    w_req_next   = 1'b1;
                    w_id_next    = w_cand.idx[W_ID-1:0];
                    w_vec_next   = VEC_BASE + 32'(w_cand.idx) * VEC_STRIDE;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    w_state_next = IDLE;
                    w_req_next   = 1'b0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_irq_req    <= 1'b0;
            r_irq_id     <= '0;
            r_irq_vector <= '0;
        end else begin
            r_state      <= w_state_next;
            r_irq_req    <= w_req_next;
            r_irq_id     <= w_id_next;
            r_irq_vector <= w_vec_next;
        end
    end

    // A fresh edge outranks the ack clear so a re-raised line is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending    <= '0;
            r_in_service <= '0;
        end else begin
            r_pending    <= (r_pending & ~w_ack_set) | w_edge;
            r_in_service <= (r_in_service & ~w_uret_clr) | w_ack_set;
        end
    end

    assign irq_req    = r_irq_req;
    assign irq_id     = r_irq_id;
    assign irq_vector = r_irq_vector;
    assign pending    = r_pending;
    assign in_service = r_in_service;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed self-checking bench for irq_controller
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  irq_in;
    logic        irq_en;
    logic        irq_ack;
    logic        uret;
    logic        irq_req;
    logic [1:0]  irq_id;
    logic [31:0] irq_vector;
    logic [2:0]  pending;
    logic [2:0]  in_service;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    irq_controller dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .irq_en     (irq_en),
        .irq_ack    (irq_ack),
        .uret       (uret),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .irq_vector (irq_vector),
        .pending    (pending),
        .in_service (in_service)
    );

    typedef struct {
        logic [2:0]  in;
        logic [1:0]  id;
        logic [31:0] vec;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        irq_in  = '0;
        irq_ack = 1'b0;
        uret    = 1'b0;
        irq_en  = 1'b1;
        ticks(2);
        rst = 1'b1;
        tick();
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (!irq_req && k < 20) begin
            tick();
            k++;
        end
        check(name, 32'(irq_req), 32'd1);
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic pulse_uret();
        uret = 1'b1;
        tick();
        uret = 1'b0;
    endtask

    initial begin
        tbl[0] = '{3'b001, 2'd0, 32'h0000_0100};
        tbl[1] = '{3'b010, 2'd1, 32'h0000_0104};
        tbl[2] = '{3'b100, 2'd2, 32'h0000_0108};
        tbl[3] = '{3'b101, 2'd2, 32'h0000_0108};
        tbl[4] = '{3'b011, 2'd1, 32'h0000_0104};
        tbl[5] = '{3'b111, 2'd2, 32'h0000_0108};

        rst = 1'b0; irq_in = '0; irq_en = 1'b0; irq_ack = 1'b0; uret = 1'b0;
        #2;
        check("rst_req", 32'(irq_req), 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        check("rst_vec", irq_vector, 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_in_service", 32'(in_service), 32'd0);

        // Latency and single-request table.
        for (int i = 0; i < 6; i++) begin
            logic [2:0] is_exp;
            is_exp = 3'b001 << tbl[i].id;
            do_reset();
            irq_in = tbl[i].in;
            ticks(3);
            check($sformatf("v%0d_e3_pending", i), 32'(pending), 32'(tbl[i].in));
            check($sformatf("v%0d_e3_req", i), 32'(irq_req), 32'd0);
            tick();
            check($sformatf("v%0d_e4_req", i), 32'(irq_req), 32'd1);
            check($sformatf("v%0d_id", i), 32'(irq_id), 32'(tbl[i].id));
            check($sformatf("v%0d_vec", i), irq_vector, tbl[i].vec);
            pulse_ack();
            check($sformatf("v%0d_ack_is", i), 32'(in_service), 32'(is_exp));
            check($sformatf("v%0d_ack_pend", i), 32'(pending), 32'(tbl[i].in & ~is_exp));
            check($sformatf("v%0d_ack_req", i), 32'(irq_req), 32'd0);
        end

        // Asynchronous reset while requesting.
        do_reset();
        irq_in = 3'b010;
        wait_req("rmid_req");
        check("rmid_id", 32'(irq_id), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("rmid_async_req", 32'(irq_req), 32'd0);
        check("rmid_async_vec", irq_vector, 32'd0);
        check("rmid_async_pend", 32'(pending), 32'd0);
        #2 rst = 1'b1;
        tick();
        wait_req("rmid_rereq");
        check("rmid_reid", 32'(irq_id), 32'd1);

        // Priority, and masking of lower lines until uret.
        do_reset();
        irq_in = 3'b101;
        wait_req("prio_req");
        check("prio_id", 32'(irq_id), 32'd2);
        check("prio_vec", irq_vector, 32'h108);
        pulse_ack();
        ticks(5);
        check("prio_masked_req", 32'(irq_req), 32'd0);
        check("prio_masked_pend", 32'(pending), 32'b001);
        pulse_uret();
        check("prio_uret_is", 32'(in_service), 32'd0);
        wait_req("prio_low_req");
        check("prio_low_id", 32'(irq_id), 32'd0);
        check("prio_low_vec", irq_vector, 32'h100);

        // Nesting.
        do_reset();
        irq_in = 3'b001;
        wait_req("nest_req0");
        pulse_ack();
        check("nest_is1", 32'(in_service), 32'b001);
        irq_in = 3'b011;
        wait_req("nest_req1");
        check("nest_id1", 32'(irq_id), 32'd1);
        pulse_ack();
        check("nest_is2", 32'(in_service), 32'b011);
        pulse_uret();
        check("nest_uret1", 32'(in_service), 32'b001);
        pulse_uret();
        check("nest_uret2", 32'(in_service), 32'b000);
        pulse_uret();
        check("nest_uret_empty", 32'(in_service), 32'b000);

        // Frozen handshake.
        do_reset();
        irq_in = 3'b001;
        wait_req("frz_req");
        irq_in = 3'b101;
        irq_en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("frz_hold_req%0d", c), 32'(irq_req), 32'd1);
            check($sformatf("frz_hold_id%0d", c), 32'(irq_id), 32'd0);
        end
        pulse_ack();
        check("frz_ack_is", 32'(in_service), 32'b001);
        ticks(4);
        check("frz_dis_req", 32'(irq_req), 32'd0);
        check("frz_dis_pend", 32'(pending), 32'b100);
        irq_en = 1'b1;
        wait_req("frz_en_req");
        check("frz_en_id", 32'(irq_id), 32'd2);
        check("frz_en_vec", irq_vector, 32'h108);

        // Edge on the acked line during the ack cycle.
        do_reset();
        irq_in = 3'b001;
        wait_req("eack_req");
        irq_in = 3'b000;
        ticks(4);
        irq_in = 3'b001;
        ticks(2);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("eack_pend", 32'(pending), 32'b001);
        check("eack_is", 32'(in_service), 32'b001);
        ticks(4);
        check("eack_same_level_req", 32'(irq_req), 32'd0);
        pulse_uret();
        wait_req("eack_rereq");
        check("eack_reid", 32'(irq_id), 32'd0);

        // uret and ack together.
        do_reset();
        irq_in = 3'b010;
        wait_req("ua_req1");
        pulse_ack();
        check("ua_is1", 32'(in_service), 32'b010);
        irq_in = 3'b110;
        wait_req("ua_req2");
        check("ua_id2", 32'(irq_id), 32'd2);
        irq_ack = 1'b1;
        uret    = 1'b1;
        tick();
        irq_ack = 1'b0;
        uret    = 1'b0;
        check("ua_is_both", 32'(in_service), 32'b100);
        check("ua_req_low", 32'(irq_req), 32'd0);

        // Repeated edges while pending collapse into one request.
        do_reset();
        irq_en = 1'b0;
        irq_in = 3'b010;
        ticks(3);
        irq_in = 3'b000;
        ticks(3);
        irq_in = 3'b010;
        ticks(3);
        check("rep_pend", 32'(pending), 32'b010);
        irq_en = 1'b1;
        wait_req("rep_req");
        check("rep_id", 32'(irq_id), 32'd1);
        pulse_ack();
        check("rep_pend_clr", 32'(pending), 32'b000);
        ticks(5);
        check("rep_no_second", 32'(irq_req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
